// File: rtl/register_file.sv
// Multi-ported register file: one write port, two combinational read ports,
// optional hard-wired zero register, optional write-to-read bypass and a saturating write counter.
module register_file #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 0,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic [15:0]      wr_count
);

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_ok;
    logic             fwd_ok;

    // A write to the hard-wired zero register is discarded and never counted.
    assign wr_ok  = we && !((ZERO_REG != 0) && (wa == '0));
    assign fwd_ok = (BYPASS != 0) && wr_ok && !reset;

    // Storage and write counter; reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else if (wr_ok) begin
            regs[wa] <= wd;
            if (wr_count != COUNT_MAX) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    always_comb begin
        rd1 = regs[ra1];
        if ((ZERO_REG != 0) && (ra1 == '0)) begin
            rd1 = '0;
        end else if (fwd_ok && (ra1 == wa)) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = regs[ra2];
        if ((ZERO_REG != 0) && (ra2 == '0)) begin
            rd2 = '0;
        end else if (fwd_ok && (ra2 == wa)) begin
            rd2 = wd;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: default configuration plus bypass variants
// with and without the zero register, all driven from the same stimulus.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;

    logic [31:0] d_rd1, d_rd2, b_rd1, b_rd2, n_rd1, n_rd2;
    logic [15:0] d_cnt, b_cnt, n_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    register_file u_dut (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(d_rd1), .rd2(d_rd2), .wr_count(d_cnt)
    );

    register_file #(.ZERO_REG(1), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(b_rd1), .rd2(b_rd2), .wr_count(b_cnt)
    );

    register_file #(.ZERO_REG(0), .BYPASS(1)) u_nz (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(n_rd1), .rd2(n_rd2), .wr_count(n_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = 5'd5; ra2 = 5'd7;
        tick();
        reset = 1'b0;
        #1;
        check("reset_rd1", d_rd1, 32'h0);
        check("reset_rd2", d_rd2, 32'h0);
        check("reset_cnt", 32'(d_cnt), 32'h0);

        // Basic write then read
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        tick();
        we = 1'b0;
        #1;
        check("wr5_rd1", d_rd1, 32'hDEADBEEF);
        check("wr5_cnt", 32'(d_cnt), 32'd1);

        // Write to address 0
        we = 1'b1; wa = 5'd0; wd = 32'h12345678; ra1 = 5'd0;
        #1;
        check("z0_dut_same", d_rd1, 32'h0);
        check("z0_byp_nofwd", b_rd1, 32'h0);
        check("z0_nz_fwd", n_rd1, 32'h12345678);
        tick();
        we = 1'b0;
        #1;
        check("z0_dut_next", d_rd1, 32'h0);
        check("z0_dut_cnt", 32'(d_cnt), 32'd1);
        check("z0_byp_cnt", 32'(b_cnt), 32'd1);
        check("z0_nz_stored", n_rd1, 32'h12345678);
        check("z0_nz_cnt", 32'(n_cnt), 32'd2);

        // Bypass versus no bypass on reg 7
        we = 1'b1; wa = 5'd7; wd = 32'h1;
        tick();
        wd = 32'h2; ra2 = 5'd7;
        #1;
        check("nobyp_old", d_rd2, 32'h1);
        check("byp_new", b_rd2, 32'h2);
        check("byp_nz_new", n_rd2, 32'h2);
        tick();
        we = 1'b0; ra1 = 5'd7;
        #1;
        check("nobyp_after", d_rd2, 32'h2);
        check("same_addr_rd1", d_rd1, 32'h2);
        check("same_addr_rd2", d_rd2, 32'h2);
        check("cnt_after7", 32'(d_cnt), 32'd3);

        // Reset against a simultaneous write
        we = 1'b1; wa = 5'd3; wd = 32'hAA;
        tick();
        reset = 1'b1; wd = 32'hFF; ra1 = 5'd3;
        #1;
        check("rst_no_fwd", b_rd1, 32'hAA);
        check("rst_no_async", d_rd1, 32'hAA);
        check("rst_cnt_before", 32'(d_cnt), 32'd4);
        tick();
        reset = 1'b0; we = 1'b0;
        #1;
        check("rst_reg3", d_rd1, 32'h0);
        check("rst_reg7", d_rd2, 32'h0);
        check("rst_cnt", 32'(d_cnt), 32'd0);
        check("rst_nz_cnt", 32'(n_cnt), 32'd0);

        // Fill every non-zero address with its own index
        we = 1'b1;
        for (int i = 1; i < 32; i++) begin
            wa = 5'(i); wd = 32'(i);
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            #1;
            check("sweep_rd1", d_rd1, 32'(i));
            check("sweep_rd2", d_rd2, 32'(31 - i));
        end
        check("sweep_cnt", 32'(d_cnt), 32'd31);

        // Saturation of the write counter
        we = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            wa = 5'((i % 31) + 1); wd = 32'(i);
            tick();
        end
        #1;
        check("sat_cnt", 32'(d_cnt), 32'h0000FFFF);
        tick();
        tick();
        check("sat_hold", 32'(d_cnt), 32'h0000FFFF);
        we = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("sat_reset", 32'(d_cnt), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the data width of every register in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, the number of registers (power of two, minimum 2).
REQ-003 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as zero and ignores writes.
REQ-004 The block SHALL have parameter BYPASS, default 0; when 1, a same-cycle write is forwarded to matching read ports.
REQ-005 The block SHALL derive AW = log2(DEPTH) as its address width.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-008 we  input  1  write enable.
REQ-009 wa  input  AW  write address.
REQ-010 wd  input  WIDTH  write data.
REQ-011 ra1  input  AW  read port 1 address.
REQ-012 ra2  input  AW  read port 2 address.
REQ-013 rd1  output  WIDTH  read port 1 data.
REQ-014 rd2  output  WIDTH  read port 2 data.
REQ-015 wr_count  output  16  number of accepted writes since reset, saturating.

Function
REQ-016 Storage SHALL be DEPTH registers of WIDTH bits, updated only on rising edge of clk.
REQ-017 When reset=0, we=1 and the target is writable, register[wa] SHALL take wd at the rising edge; contents are visible on read ports from the following cycle.
REQ-018 When we=0, no register SHALL change.
REQ-019 Reads SHALL be combinational: rd1 = register[ra1], rd2 = register[ra2], zero-latency from address change.
REQ-020 With ZERO_REG=1, a write to address 0 SHALL be discarded and rd1/rd2 SHALL be all-zero whenever the corresponding address is 0, in every cycle.
REQ-021 With ZERO_REG=0, register 0 SHALL behave as any other register.
REQ-022 With BYPASS=1, when we=1, reset=0 and rdN address equals wa (and wa is writable), rdN SHALL present wd in the same cycle; a discarded write to address 0 SHALL NOT be bypassed.
REQ-023 With BYPASS=0, a read of the address being written SHALL return the old value until the rising edge.
REQ-024 Both read ports SHALL operate independently; ra1=ra2 SHALL return identical data.
REQ-025 wr_count SHALL increment by 1 on each rising edge where a write is accepted (writes discarded per REQ-020 not counted), and SHALL hold at 16'hFFFF once reached (no wrap).
REQ-026 Out-of-range addresses cannot occur (DEPTH = 2^AW); no error handling is required.

Reset
REQ-027 When reset=1 at a rising edge, every register and wr_count SHALL become 0, regardless of we.
REQ-028 reset SHALL take priority over a simultaneous write; the write SHALL be lost and SHALL NOT be counted.
REQ-029 While reset=1, bypass SHALL be suppressed; rd1/rd2 reflect stored contents (all zero after the first reset edge).
REQ-030 Reset asserted mid-operation SHALL clear all state on the next rising edge; no asynchronous effect before that edge.
REQ-031 After reset deasserts, the first rising edge with we=1 SHALL be accepted normally.

Verification
REQ-032 Reset 1 cycle, then we=1, wa=5, wd=32'hDEADBEEF; next cycle ra1=5 -> rd1=32'hDEADBEEF, wr_count=1.
REQ-033 ZERO_REG=1: we=1, wa=0, wd=32'h12345678; ra1=0 -> rd1=0 same and next cycle, wr_count unchanged.
REQ-034 BYPASS=1: reg 7 holds 32'h1, drive we=1, wa=7, wd=32'h2, ra2=7 -> rd2=32'h2 in same cycle; BYPASS=0 -> rd2=32'h1 until edge, then 32'h2.
REQ-035 reset=1 and we=1, wa=3, wd=32'hFF on same edge -> reg 3 = 0, wr_count=0 after edge.
REQ-036 Write all 31 non-zero addresses with value = address, then ra1 and ra2 sweep 0..31 -> rd = address (0 at address 0), wr_count=31.
REQ-037 Force 65540 accepted writes -> wr_count=16'hFFFF and stays there; then reset -> wr_count=0.
